// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-SRAM responder: FSM encoding and wait-state limit.
// No logic; constants and types only.
// The 4-bit wait counter bounds WAIT_CYCLES to 15.
package data_sram_responder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int unsigned WAIT_CYCLES_MAX = 15;

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data-SRAM bus: request (en/wen/addr/wdata) towards the RAM, rdata/stall/err/busy back.
// Purely structural, no latency.
// The CPU holds the request stable while stall is high.
interface data_sram_responder_if;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stall;
  logic        err;
  logic        busy;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stall, err, busy
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stall, err, busy
  );

endinterface

// File: rtl/data_sram_responder_sram_byte_array.sv
// Word-addressed 32-bit storage with per-byte write enables and a registered read port.
// Read data appears one edge after i_rd; writes land at the edge where i_wr is high.
// No backpressure: the caller strobes i_wr/i_rd only on the commit cycle.
module sram_byte_array #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_wr,
  input  logic              i_rd,
  input  logic [3:0]        i_wen,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_q;

  // Byte-lane writes and synchronous read; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (i_wen[i]) begin
          r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
    if (i_rd) begin
      r_q <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: owns the RAM, inserts WAIT_CYCLES stall cycles, flags out-of-window accesses.
// Access commits WAIT_CYCLES cycles after the request is first seen; rdata valid the cycle after.
// stall is high combinationally until the commit cycle; request is latched so later input changes are ignored.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned         ADDR_W      = 12,
  parameter int unsigned         WAIT_CYCLES = 2,
  parameter logic [29-ADDR_W:0]  BASE_HI     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  data_sram_responder_if.slave  bus
);

  localparam logic [3:0] LP_WAIT      = 4'(WAIT_CYCLES);
  localparam bit         LP_ZERO_WAIT = (WAIT_CYCLES == 0);

  if (WAIT_CYCLES > WAIT_CYCLES_MAX) begin : g_bad_wait_cycles
    $error("data_sram_responder: WAIT_CYCLES must be in 0..15");
  end

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:2] r_addr;
  logic [3:0]  r_wen;
  logic [31:0] r_wdata;
  logic        r_err;
  logic        r_busy;
  logic        r_rd_zero;

  logic        w_req_new;
  logic        w_in_wait;
  logic        w_commit;
  logic [31:2] w_c_addr;
  logic [3:0]  w_c_wen;
  logic [31:0] w_c_wdata;
  logic        w_in_win;
  logic        w_c_rd;
  logic        w_ram_wr;
  logic        w_ram_rd;
  logic [31:0] w_ram_q;
  logic        w_unused_addr_lsb;

  assign w_req_new = (r_state == ST_IDLE) && bus.data_sram_en;
  assign w_in_wait = (r_state == ST_WAIT);

  // With zero wait states the live request commits straight from IDLE.
  assign w_commit = (w_req_new && LP_ZERO_WAIT) || (w_in_wait && (r_cnt == LP_WAIT));

  // Commit uses the latched request in WAIT, the live inputs otherwise.
  assign w_c_addr  = w_in_wait ? r_addr  : bus.data_sram_addr[31:2];
  assign w_c_wen   = w_in_wait ? r_wen   : bus.data_sram_wen;
  assign w_c_wdata = w_in_wait ? r_wdata : bus.data_sram_wdata;

  assign w_in_win = (w_c_addr[31:ADDR_W+2] == BASE_HI);
  assign w_c_rd   = (w_c_wen == 4'b0000);

  // A reset landing on the commit edge must not disturb the RAM.
  assign w_ram_wr = w_commit && !rst && w_in_win && !w_c_rd;
  assign w_ram_rd = w_commit && !rst && w_in_win && w_c_rd;

  assign w_unused_addr_lsb = ^bus.data_sram_addr[1:0];

  sram_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk),
    .i_wr    (w_ram_wr),
    .i_rd    (w_ram_rd),
    .i_wen   (w_c_wen),
    .i_idx   (w_c_addr[ADDR_W+1:2]),
    .i_wdata (w_c_wdata),
    .o_rdata (w_ram_q)
  );

  // Request FSM, wait counter, request latch, error pulse and read-zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_wen     <= 4'b0000;
      r_wdata   <= 32'h0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_rd_zero <= 1'b1;
    end else begin
      r_err <= w_commit && !w_in_win;
      if (w_commit && w_c_rd) begin
        r_rd_zero <= !w_in_win;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.data_sram_en && !LP_ZERO_WAIT) begin
            r_addr  <= bus.data_sram_addr[31:2];
            r_wen   <= bus.data_sram_wen;
            r_wdata <= bus.data_sram_wdata;
            r_cnt   <= 4'd1;
            r_state <= ST_WAIT;
            r_busy  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_cnt == LP_WAIT) begin
            r_cnt   <= 4'd0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Out-of-window reads (and reset) present zero without touching the RAM read register.
  assign bus.data_sram_rdata = r_rd_zero ? 32'h0 : w_ram_q;
  assign bus.stall = (w_req_new && !LP_ZERO_WAIT) || (w_in_wait && (r_cnt < LP_WAIT));
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: one DUT with 2 wait states, one with none.
// Expected values are hand-computed constants.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_data_sram_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  data_sram_responder_if u_if2 ();
  data_sram_responder_if u_if0 ();

  data_sram_responder #(
    .ADDR_W      (12),
    .WAIT_CYCLES (2),
    .BASE_HI     (20'h00000)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (u_if2.slave)
  );

  data_sram_responder #(
    .ADDR_W      (12),
    .WAIT_CYCLES (0),
    .BASE_HI     (20'h00000)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (u_if0.slave)
  );

  // One access on the 2-wait DUT, starting just after a rising edge; returns just after the commit edge.
  task automatic acc2(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                      output int nstall, output int nbusy);
    nstall = 0;
    nbusy  = 0;
    u_if2.data_sram_en    = 1'b1;
    u_if2.data_sram_wen   = wen;
    u_if2.data_sram_addr  = addr;
    u_if2.data_sram_wdata = wdata;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (u_if2.busy) nbusy++;
      if (u_if2.stall) begin
        nstall++;
        @(posedge clk);
        #1;
      end else begin
        break;
      end
    end
    @(posedge clk);
    #1;
    u_if2.data_sram_en    = 1'b0;
    u_if2.data_sram_wen   = 4'b0000;
    u_if2.data_sram_addr  = 32'h0;
    u_if2.data_sram_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (u_if2.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall2: got %b want 0", u_if2.stall); end
    n_checks++; if (u_if2.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy2: got %b want 0", u_if2.busy); end
    n_checks++; if (u_if2.err !== 1'b0) begin n_fail++; $display("FAIL rst_err2: got %b want 0", u_if2.err); end
    n_checks++; if (u_if2.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata2: got %h want 0", u_if2.data_sram_rdata); end
    n_checks++; if (u_if0.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall0: got %b want 0", u_if0.stall); end
    n_checks++; if (u_if0.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata0: got %h want 0", u_if0.data_sram_rdata); end
  endtask

  task automatic test_write_read();
    int ns, nb;
    @(posedge clk); #1;
    acc2(4'hF, 32'h0000_0010, 32'hDEADBEEF, ns, nb);
    n_checks++; if (ns !== 2) begin n_fail++; $display("FAIL wr_stall_cycles: got %0d want 2", ns); end
    n_checks++; if (nb !== 2) begin n_fail++; $display("FAIL wr_busy_cycles: got %0d want 2", nb); end
    @(negedge clk);
    n_checks++; if (u_if2.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_hold: got %h want 0", u_if2.data_sram_rdata); end
    n_checks++; if (u_if2.err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", u_if2.err); end
    @(posedge clk); #1;
    acc2(4'h0, 32'h0000_0010, 32'h0, ns, nb);
    n_checks++; if (ns !== 2) begin n_fail++; $display("FAIL rd_stall_cycles: got %0d want 2", ns); end
    @(negedge clk);
    n_checks++; if (u_if2.data_sram_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", u_if2.data_sram_rdata); end
    n_checks++; if (u_if2.busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_after: got %b want 0", u_if2.busy); end
  endtask

  task automatic test_byte_write();
    int ns, nb;
    @(posedge clk); #1;
    acc2(4'hF, 32'h0000_0014, 32'h11223344, ns, nb);
    acc2(4'b0010, 32'h0000_0014, 32'h0000AA00, ns, nb);
    acc2(4'h0, 32'h0000_0014, 32'h0, ns, nb);
    @(negedge clk);
    n_checks++; if (u_if2.data_sram_rdata !== 32'h1122AA44) begin n_fail++; $display("FAIL byte_lane1: got %h want 1122aa44", u_if2.data_sram_rdata); end
    @(posedge clk); #1;
    acc2(4'b1001, 32'h0000_0014, 32'h55000066, ns, nb);
    acc2(4'h0, 32'h0000_0014, 32'h0, ns, nb);
    @(negedge clk);
    n_checks++; if (u_if2.data_sram_rdata !== 32'h5522AA66) begin n_fail++; $display("FAIL byte_lane03: got %h want 5522aa66", u_if2.data_sram_rdata); end
  endtask

  task automatic test_out_of_window();
    int ns, nb;
    @(posedge clk); #1;
    acc2(4'hF, 32'h0000_0000, 32'hCAFEF00D, ns, nb);
    acc2(4'h0, 32'h0001_0000, 32'h0, ns, nb);
    n_checks++; if (ns !== 2) begin n_fail++; $display("FAIL oow_rd_stall: got %0d want 2", ns); end
    @(negedge clk);
    n_checks++; if (u_if2.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL oow_rd_zero: got %h want 0", u_if2.data_sram_rdata); end
    n_checks++; if (u_if2.err !== 1'b1) begin n_fail++; $display("FAIL oow_rd_err: got %b want 1", u_if2.err); end
    @(negedge clk);
    n_checks++; if (u_if2.err !== 1'b0) begin n_fail++; $display("FAIL oow_err_pulse: got %b want 0", u_if2.err); end
    @(posedge clk); #1;
    acc2(4'hF, 32'h0001_0000, 32'h12345678, ns, nb);
    n_checks++; if (ns !== 2) begin n_fail++; $display("FAIL oow_wr_stall: got %0d want 2", ns); end
    @(negedge clk);
    n_checks++; if (u_if2.err !== 1'b1) begin n_fail++; $display("FAIL oow_wr_err: got %b want 1", u_if2.err); end
    @(posedge clk); #1;
    acc2(4'h0, 32'h0000_0000, 32'h0, ns, nb);
    @(negedge clk);
    n_checks++; if (u_if2.data_sram_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL oow_ram_intact: got %h want cafef00d", u_if2.data_sram_rdata); end
    n_checks++; if (u_if2.err !== 1'b0) begin n_fail++; $display("FAIL inwin_err: got %b want 0", u_if2.err); end
  endtask

  task automatic test_latched_request();
    int ns, nb;
    @(posedge clk); #1;
    acc2(4'hF, 32'h0000_0034, 32'h0, ns, nb);
    u_if2.data_sram_en    = 1'b1;
    u_if2.data_sram_wen   = 4'hF;
    u_if2.data_sram_addr  = 32'h0000_0030;
    u_if2.data_sram_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    u_if2.data_sram_wen   = 4'h0;
    u_if2.data_sram_addr  = 32'h0000_0034;
    u_if2.data_sram_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    u_if2.data_sram_en = 1'b0;
    @(posedge clk); #1;
    acc2(4'h0, 32'h0000_0034, 32'h0, ns, nb);
    @(negedge clk);
    n_checks++; if (u_if2.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL latch_other_word: got %h want 0", u_if2.data_sram_rdata); end
    @(posedge clk); #1;
    acc2(4'h0, 32'h0000_0030, 32'h0, ns, nb);
    @(negedge clk);
    n_checks++; if (u_if2.data_sram_rdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL latch_data: got %h want a5a5a5a5", u_if2.data_sram_rdata); end
  endtask

  task automatic test_reset_in_wait();
    int ns, nb;
    @(posedge clk); #1;
    acc2(4'hF, 32'h0000_0020, 32'h0BADC0DE, ns, nb);
    u_if2.data_sram_en    = 1'b1;
    u_if2.data_sram_wen   = 4'hF;
    u_if2.data_sram_addr  = 32'h0000_0020;
    u_if2.data_sram_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    n_checks++; if (u_if2.stall !== 1'b1) begin n_fail++; $display("FAIL rw_stall_idle: got %b want 1", u_if2.stall); end
    @(posedge clk); #1;
    u_if2.data_sram_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (u_if2.busy !== 1'b1) begin n_fail++; $display("FAIL rw_busy_wait: got %b want 1", u_if2.busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (u_if2.stall !== 1'b0) begin n_fail++; $display("FAIL rw_stall_after: got %b want 0", u_if2.stall); end
    n_checks++; if (u_if2.busy !== 1'b0) begin n_fail++; $display("FAIL rw_busy_after: got %b want 0", u_if2.busy); end
    n_checks++; if (u_if2.err !== 1'b0) begin n_fail++; $display("FAIL rw_err_after: got %b want 0", u_if2.err); end
    n_checks++; if (u_if2.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL rw_rdata_after: got %h want 0", u_if2.data_sram_rdata); end
    @(posedge clk); #1;
    acc2(4'h0, 32'h0000_0020, 32'h0, ns, nb);
    @(negedge clk);
    n_checks++; if (u_if2.data_sram_rdata !== 32'h0BADC0DE) begin n_fail++; $display("FAIL rw_ram_intact: got %h want 0badc0de", u_if2.data_sram_rdata); end
  endtask

  task automatic test_back_to_back_raw();
    int ns, nb;
    @(posedge clk); #1;
    acc2(4'hF, 32'h0000_0040, 32'h01020304, ns, nb);
    acc2(4'h0, 32'h0000_0040, 32'h0, ns, nb);
    n_checks++; if (ns !== 2) begin n_fail++; $display("FAIL raw_stall: got %0d want 2", ns); end
    @(negedge clk);
    n_checks++; if (u_if2.data_sram_rdata !== 32'h01020304) begin n_fail++; $display("FAIL raw_data: got %h want 01020304", u_if2.data_sram_rdata); end
  endtask

  task automatic test_zero_wait();
    @(posedge clk); #1;
    u_if0.data_sram_en    = 1'b1;
    u_if0.data_sram_wen   = 4'hF;
    u_if0.data_sram_addr  = 32'h0000_0004;
    u_if0.data_sram_wdata = 32'h44444444;
    @(negedge clk);
    n_checks++; if (u_if0.stall !== 1'b0) begin n_fail++; $display("FAIL w0_stall_wr: got %b want 0", u_if0.stall); end
    @(posedge clk); #1;
    u_if0.data_sram_addr  = 32'h0000_0008;
    u_if0.data_sram_wdata = 32'h88888888;
    @(negedge clk);
    n_checks++; if (u_if0.busy !== 1'b0) begin n_fail++; $display("FAIL w0_busy: got %b want 0", u_if0.busy); end
    @(posedge clk); #1;
    u_if0.data_sram_wen  = 4'h0;
    u_if0.data_sram_addr = 32'h0000_0004;
    @(negedge clk);
    n_checks++; if (u_if0.stall !== 1'b0) begin n_fail++; $display("FAIL w0_stall_rd: got %b want 0", u_if0.stall); end
    n_checks++; if (u_if0.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL w0_rdata_hold: got %h want 0", u_if0.data_sram_rdata); end
    @(posedge clk); #1;
    u_if0.data_sram_addr = 32'h0000_0008;
    @(negedge clk);
    n_checks++; if (u_if0.data_sram_rdata !== 32'h44444444) begin n_fail++; $display("FAIL w0_rd4: got %h want 44444444", u_if0.data_sram_rdata); end
    @(posedge clk); #1;
    u_if0.data_sram_en = 1'b0;
    @(negedge clk);
    n_checks++; if (u_if0.data_sram_rdata !== 32'h88888888) begin n_fail++; $display("FAIL w0_rd8: got %h want 88888888", u_if0.data_sram_rdata); end
    n_checks++; if (u_if0.stall !== 1'b0) begin n_fail++; $display("FAIL w0_stall_end: got %b want 0", u_if0.stall); end
  endtask

  initial begin
    u_if2.data_sram_en    = 1'b0;
    u_if2.data_sram_wen   = 4'h0;
    u_if2.data_sram_addr  = 32'h0;
    u_if2.data_sram_wdata = 32'h0;
    u_if0.data_sram_en    = 1'b0;
    u_if0.data_sram_wen   = 4'h0;
    u_if0.data_sram_addr  = 32'h0;
    u_if0.data_sram_wdata = 32'h0;
    test_reset();
    test_write_read();
    test_byte_write();
    test_out_of_window();
    test_latched_request();
    test_reset_in_wait();
    test_back_to_back_raw();
    test_zero_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
